// File: rtl/div_clk_monitor_if.sv
// Signal bundle between a divided-clock source / test controller and div_clk_monitor.
// The master side drives the clock under test and the expectations; the slave side reports.
interface div_clk_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             clk_in;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             period_err;
  logic             duty_err;
  logic             lost_clk;

  modport master (
    output en, clk_in, exp_period, exp_high,
    input  meas_period, meas_high, meas_valid, period_err, duty_err, lost_clk
  );

  modport slave (
    input  en, clk_in, exp_period, exp_high,
    output meas_period, meas_high, meas_valid, period_err, duty_err, lost_clk
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Measures period and high time of a divided clock (sampled as data) in clk cycles and flags
// period, duty and lost-clock faults against programmed expectations.
module div_clk_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOL         = 1,
  parameter int unsigned TIMEOUT     = 65535
) (
  input logic              clk,
  input logic              rst_n,
  div_clk_monitor_if.slave mon_io
);

  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TolC     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] OneC     = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StWaitRise, StMeasHigh, StMeasLow} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       per_cnt_q;
  logic [CNT_W-1:0]       hi_cnt_q;
  logic [CNT_W-1:0]       hi_cap_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic [CNT_W-1:0]       meas_period_q;
  logic [CNT_W-1:0]       meas_high_q;
  logic                   meas_valid_q;
  logic                   period_err_q;
  logic                   duty_err_q;
  logic                   lost_clk_q;

  logic sync_out;
  logic rise;
  logic fall;

  // Difference widened by one bit so the sign survives before taking the magnitude.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[CNT_W] ? (~d + 1'b1) : d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_io.clk_in};
      prev_q <= sync_out;
    end
  end

  always_comb begin
    sync_out = sync_q[SYNC_STAGES-1];
    rise     = sync_out & ~prev_q;
    fall     = ~sync_out & prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      hi_cap_q      <= '0;
      wait_cnt_q    <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
      period_err_q  <= 1'b0;
      duty_err_q    <= 1'b0;
      lost_clk_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!mon_io.en) begin
        // Measurement results are kept; status flags and counters are cleared.
        state_q      <= StIdle;
        per_cnt_q    <= '0;
        hi_cnt_q     <= '0;
        hi_cap_q     <= '0;
        wait_cnt_q   <= '0;
        period_err_q <= 1'b0;
        duty_err_q   <= 1'b0;
        lost_clk_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q    <= StWaitRise;
            wait_cnt_q <= OneC;
          end
          StWaitRise: begin
            if (rise) begin
              state_q    <= StMeasHigh;
              per_cnt_q  <= OneC;
              hi_cnt_q   <= OneC;
              wait_cnt_q <= '0;
              lost_clk_q <= 1'b0;
            end else if (fall) begin
              wait_cnt_q <= OneC;
            end else if (wait_cnt_q == TimeoutC) begin
              wait_cnt_q <= OneC;
              lost_clk_q <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
          StMeasHigh: begin
            if (fall) begin
              state_q   <= StMeasLow;
              hi_cap_q  <= hi_cnt_q;
              per_cnt_q <= per_cnt_q + 1'b1;
            end else if (per_cnt_q == TimeoutC) begin
              state_q    <= StWaitRise;
              per_cnt_q  <= '0;
              hi_cnt_q   <= '0;
              wait_cnt_q <= OneC;
              lost_clk_q <= 1'b1;
            end else begin
              per_cnt_q <= per_cnt_q + 1'b1;
              hi_cnt_q  <= hi_cnt_q + 1'b1;
            end
          end
          StMeasLow: begin
            if (rise) begin
              state_q       <= StMeasHigh;
              meas_period_q <= per_cnt_q;
              meas_high_q   <= hi_cap_q;
              meas_valid_q  <= 1'b1;
              period_err_q  <= abs_diff(per_cnt_q, mon_io.exp_period) > TolC;
              duty_err_q    <= abs_diff(hi_cap_q, mon_io.exp_high) > TolC;
              per_cnt_q     <= OneC;
              hi_cnt_q      <= OneC;
            end else if (per_cnt_q == TimeoutC) begin
              state_q    <= StWaitRise;
              per_cnt_q  <= '0;
              hi_cnt_q   <= '0;
              wait_cnt_q <= OneC;
              lost_clk_q <= 1'b1;
            end else begin
              per_cnt_q <= per_cnt_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign mon_io.meas_period = meas_period_q;
  assign mon_io.meas_high   = meas_high_q;
  assign mon_io.meas_valid  = meas_valid_q;
  assign mon_io.period_err  = period_err_q;
  assign mon_io.duty_err    = duty_err_q;
  assign mon_io.lost_clk    = lost_clk_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: timestamp-based reference model feeding an event scoreboard,
// plus per-cycle output comparison and directed checks.
module tb_div_clk_monitor;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TOL         = 1;
  localparam int unsigned TIMEOUT     = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  div_clk_monitor_if #(.CNT_W(CNT_W)) bus ();

  div_clk_monitor #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TOL        (TOL),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon_io(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit is_lost;
    int t;
    int period;
    int high;
    bit perr;
    bit derr;
  } ev_t;

  typedef enum {MOff, MHunt, MMeas} mode_e;

  ev_t   exq[$];
  mode_e m_mode;
  int    mt;
  int    t_ref, t_rise, t_fall;
  bit    fallen;
  bit    m_valid, m_perr, m_derr, m_lost;
  int    m_mp, m_mh;
  bit    hq[$];

  function automatic bit off_tol(input int a, input int b);
    return ((a > b) ? a - b : b - a) > int'(TOL);
  endfunction

  task automatic model_lost(input int u);
    ev_t e;
    if (!m_lost) begin
      e = '{is_lost: 1'b1, t: u, period: 0, high: 0, perr: 1'b0, derr: 1'b0};
      exq.push_back(e);
    end
    m_lost = 1'b1;
  endtask

  task automatic model_step();
    bit s, prev, rise, fall;
    int u;
    ev_t e;
    mt++;
    u    = mt;
    prev = hq[0];
    s    = hq[1];
    rise = s && !prev;
    fall = !s && prev;
    hq.push_back(bus.clk_in);
    void'(hq.pop_front());
    m_valid = 1'b0;
    if (!bus.en) begin
      m_mode = MOff;
      m_perr = 1'b0;
      m_derr = 1'b0;
      m_lost = 1'b0;
    end else begin
      case (m_mode)
        MOff: begin
          m_mode = MHunt;
          t_ref  = u;
        end
        MHunt: begin
          if (rise) begin
            m_mode = MMeas;
            t_rise = u;
            fallen = 1'b0;
            m_lost = 1'b0;
          end else if (fall) begin
            t_ref = u;
          end else if (u - t_ref == int'(TIMEOUT)) begin
            model_lost(u);
            t_ref = u;
          end
        end
        default: begin
          if (rise && fallen) begin
            m_mp    = u - t_rise;
            m_mh    = t_fall - t_rise;
            m_perr  = off_tol(m_mp, int'(bus.exp_period));
            m_derr  = off_tol(m_mh, int'(bus.exp_high));
            m_valid = 1'b1;
            e = '{is_lost: 1'b0, t: u, period: m_mp, high: m_mh, perr: m_perr, derr: m_derr};
            exq.push_back(e);
            t_rise = u;
            fallen = 1'b0;
          end else if (fall && !fallen) begin
            t_fall = u;
            fallen = 1'b1;
          end else if (u - t_rise == int'(TIMEOUT)) begin
            model_lost(u);
            m_mode = MHunt;
            t_ref  = u;
          end
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode  = MOff;
        m_valid = 1'b0;
        m_perr  = 1'b0;
        m_derr  = 1'b0;
        m_lost  = 1'b0;
        m_mp    = 0;
        m_mh    = 0;
        fallen  = 1'b0;
        exq.delete();
        hq.delete();
        for (int i = 0; i <= int'(SYNC_STAGES); i++) hq.push_back(1'b0);
      end else begin
        model_step();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  function automatic bit front_is(input bit lost);
    return (exq.size() > 0) && (exq[0].is_lost == lost) && (exq[0].t == mt);
  endfunction

  initial begin
    bit  lost_prev;
    ev_t e;
    lost_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lost_prev = 1'b0;
      end else begin
        while (exq.size() > 0 && exq[0].t < mt) begin
          checks++;
          errors++;
          $display("FAIL missed_event: lost=%0d expected at cycle %0d, now at cycle %0d",
                   exq[0].is_lost, exq[0].t, mt);
          void'(exq.pop_front());
        end
        if (bus.meas_valid === 1'b1) begin
          chk("valid_expected", bus.meas_valid, front_is(1'b0));
          if (front_is(1'b0)) begin
            e = exq.pop_front();
            chk("meas_period", bus.meas_period, e.period);
            chk("meas_high", bus.meas_high, e.high);
            chk("period_err", bus.period_err, e.perr);
            chk("duty_err", bus.duty_err, e.derr);
          end
        end
        if (bus.lost_clk === 1'b1 && !lost_prev) begin
          chk("lost_rise_expected", bus.lost_clk, front_is(1'b1));
          if (front_is(1'b1)) void'(exq.pop_front());
        end
        lost_prev = (bus.lost_clk === 1'b1);
        chk("output_levels",
            {bus.meas_valid, bus.period_err, bus.duty_err, bus.lost_clk,
             bus.meas_period, bus.meas_high},
            {m_valid, m_perr, m_derr, m_lost, CNT_W'(m_mp), CNT_W'(m_mh)});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.clk_in = v;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  initial begin
    int h, l, ep, eh;
    bus.en         = 1'b0;
    bus.clk_in     = 1'b0;
    bus.exp_period = '0;
    bus.exp_high   = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        {bus.meas_valid, bus.period_err, bus.duty_err, bus.lost_clk,
         bus.meas_period, bus.meas_high}, 64'd0);
    hold(1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 2);

    // clk/3, high 2 low 1
    bus.exp_period = 16'd3;
    bus.exp_high   = 16'd2;
    bus.en         = 1'b1;
    wave(2, 1, 8);
    chk("div3_period", bus.meas_period, 3);
    chk("div3_high", bus.meas_high, 2);
    chk("div3_errs", {bus.period_err, bus.duty_err}, 2'b00);

    // clk/4 50% duty against a wrong high expectation
    bus.exp_period = 16'd4;
    bus.exp_high   = 16'd0;
    wave(2, 2, 6);
    chk("div4_duty_err", bus.duty_err, 1);
    chk("div4_period_err", bus.period_err, 0);
    chk("div4_high", bus.meas_high, 2);

    // clk/5 inside then outside tolerance
    bus.exp_period = 16'd6;
    bus.exp_high   = 16'd2;
    wave(2, 3, 4);
    chk("div5_in_tol", bus.period_err, 0);
    bus.exp_period = 16'd7;
    wave(2, 3, 3);
    chk("div5_out_tol", bus.period_err, 1);

    // stuck low, then recovery
    bus.exp_period = 16'd3;
    wave(2, 1, 3);
    hold(1'b0, 30);
    chk("stuck_low_lost", bus.lost_clk, 1);
    wave(2, 1, 4);
    chk("recover_lost_clear", bus.lost_clk, 0);

    // stuck high
    hold(1'b1, 30);
    chk("stuck_high_lost", bus.lost_clk, 1);
    hold(1'b0, 2);
    wave(2, 1, 4);

    // en dropped during the high phase
    bus.exp_period = 16'd6;
    bus.exp_high   = 16'd3;
    wave(3, 3, 3);
    hold(1'b1, 4);
    bus.en = 1'b0;
    hold(1'b1, 2);
    chk("en_drop_valid_errs", {bus.meas_valid, bus.period_err, bus.duty_err, bus.lost_clk}, 0);
    chk("en_drop_period_held", bus.meas_period, 6);
    bus.en = 1'b1;
    hold(1'b0, 2);
    wave(3, 3, 4);

    // asynchronous reset in the low phase
    wave(2, 4, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {bus.meas_valid, bus.period_err, bus.duty_err, bus.lost_clk,
         bus.meas_period, bus.meas_high}, 64'd0);
    hold(1'b0, 3);
    rst_n = 1'b1;
    wave(2, 4, 4);

    // randomized divider ratios and expectations
    for (int k = 0; k < 25; k++) begin
      h = int'($urandom_range(1, 6));
      l = int'($urandom_range(1, 6));
      if ($urandom_range(0, 2) == 0) begin
        bus.en = 1'b0;
        hold(bus.clk_in, int'($urandom_range(1, 4)));
      end
      ep = h + l + int'($urandom_range(0, 4)) - 2;
      eh = h + int'($urandom_range(0, 4)) - 2;
      if (eh < 0) eh = 0;
      bus.exp_period = CNT_W'(ep);
      bus.exp_high   = CNT_W'(eh);
      bus.en         = 1'b1;
      wave(h, l, int'($urandom_range(2, 6)));
      if ($urandom_range(0, 4) == 0) hold(1'($urandom_range(0, 1)), 25);
    end

    bus.en = 1'b0;
    hold(1'b0, 5);
    chk("scoreboard_drained", exq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
